// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, request-to-send, 10 bits out, ack check).
// Optional frame watchdog compiled in with PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 7200,
  parameter int TIMEOUT_CYCLES = 900000
) (
  input  logic       clk60MHz,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAITIDLE, DONE, ERR} state_t;
  state_t r_state;
  logic [1:0] r_clk_s, r_dat_s;
  logic r_clk_prev;
  logic [9:0] r_frame;
  logic [3:0] r_idx;
  logic [IW-1:0] r_inh;
  logic r_clk_oe, r_data_oe, r_ready, r_busy, r_done, r_err;
  logic w_fall, w_watch, w_tmo, w_fail;
  assign w_fall = r_clk_prev & ~r_clk_s[1];
  assign w_watch = (r_state == SEND) || (r_state == ACK) || (r_state == WAITIDLE);
`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] r_wdog;
  assign w_tmo = w_watch && (r_wdog == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk60MHz or negedge rst_n)
    if (!rst_n) r_wdog <= '0;
    else if (r_state == REQ) r_wdog <= '0;
    else if (w_watch) r_wdog <= r_wdog + 1'b1;
`else
  assign w_tmo = 1'b0;
`endif
  // timeout takes priority over an ack edge landing in the same cycle
  assign w_fail = w_tmo || (r_state == ACK && w_fall && r_dat_s[1]);
  assign tx_ready = r_ready;
  assign busy = r_busy;
  assign done = r_done;
  assign err = r_err;
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  always_ff @(posedge clk60MHz or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
      r_clk_prev <= 1'b1;
      r_frame <= '0;
      r_idx <= '0;
      r_inh <= '0;
      r_clk_oe <= 1'b0;
      r_data_oe <= 1'b0;
      r_ready <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_clk_s <= {r_clk_s[0], ps2_clk_i};
      r_dat_s <= {r_dat_s[0], ps2_data_i};
      r_clk_prev <= r_clk_s[1];
      r_done <= 1'b0;
      r_err <= 1'b0;
      if (w_fail) begin
        r_err <= 1'b1;
        r_clk_oe <= 1'b0;
        r_data_oe <= 1'b0;
        r_state <= ERR;
      end else
        case (r_state)
          IDLE: if (tx_valid) begin
            r_frame <= {1'b1, ~^tx_data, tx_data};
            r_inh <= '0;
            r_idx <= '0;
            r_clk_oe <= 1'b1;
            r_ready <= 1'b0;
            r_busy <= 1'b1;
            r_state <= INHIBIT;
          end
          INHIBIT: if (r_inh == INH_LAST) begin
            r_data_oe <= 1'b1;
            r_state <= REQ;
          end else r_inh <= r_inh + 1'b1;
          REQ: begin
            r_clk_oe <= 1'b0;
            r_state <= SEND;
          end
          SEND: if (w_fall) begin
            r_data_oe <= ~r_frame[r_idx];
            r_idx <= r_idx + 1'b1;
            r_state <= (r_idx == 4'd9) ? ACK : SEND;
          end
          ACK: if (w_fall) r_state <= WAITIDLE;
          WAITIDLE: if (r_clk_s[1] && r_dat_s[1]) begin
            r_done <= 1'b1;
            r_state <= DONE;
          end
          DONE, ERR: begin
            r_ready <= 1'b1;
            r_busy <= 1'b0;
            r_state <= IDLE;
          end
        endcase
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a simple PS/2 device model on the open-drain pins.
module tb_ps2_host_tx;
  localparam int TMO = 3000;
  logic clk60MHz = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe;
  logic m_clk = 1'b1;
  logic m_dat = 1'b1;
  logic ps2_clk_i, ps2_data_i;
  int total = 0;
  int bad = 0;
  int n_done = 0;
  int n_err = 0;
  int run = 0;
  int hi_len = 0;
  int rise_at = 0;
  logic [1:0] err_oe = 2'b11;
  assign ps2_clk_i = m_clk & ~ps2_clk_oe;
  assign ps2_data_i = m_dat & ~ps2_data_oe;
  always #5 clk60MHz = ~clk60MHz;
  ps2_host_tx #(.INHIBIT_CYCLES(7200), .TIMEOUT_CYCLES(TMO)) dut (
    .clk60MHz(clk60MHz), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .err(err),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );
  always @(negedge clk60MHz) begin
    if (done) n_done++;
    if (err) begin
      n_err++;
      err_oe = {ps2_clk_oe, ps2_data_oe};
    end
    if (ps2_clk_oe) begin
      if (run == 0) rise_at = 0;
      run++;
      if (ps2_data_oe && rise_at == 0) rise_at = run;
    end else if (run != 0) begin
      hi_len = run;
      run = 0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk60MHz);
  endtask
  task automatic send(input logic [7:0] b);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk60MHz);
    tx_valid = 1'b0;
  endtask
  task automatic wait_release();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk60MHz);
      ok = !ps2_clk_oe;
    end
    chk("release", {31'd0, ok}, 32'd1);
  endtask
  task automatic wait_ready();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk60MHz);
      ok = tx_ready;
    end
    chk("ready_back", {31'd0, ok}, 32'd1);
    cyc(2);
  endtask
  task automatic frame(input logic ack, output logic [10:0] got);
    wait_release();
    cyc(20);
    got[0] = ps2_data_i;
    for (int k = 1; k <= 10; k++) begin
      m_clk = 1'b0;
      cyc(20);
      m_clk = 1'b1;
      cyc(20);
      got[k] = ps2_data_i;
    end
    m_dat = ack;
    cyc(5);
    m_clk = 1'b0;
    cyc(20);
    m_clk = 1'b1;
    cyc(5);
    m_dat = 1'b1;
    wait_ready();
  endtask
  initial begin
    logic [10:0] got;
    int d0, e0, n;
    cyc(3);
    chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    chk("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    rst_n = 1'b1;
    cyc(3);
    // 0xF4 with ack: bits 0,0,1,0,1,1,1,1 parity 0
    d0 = n_done; e0 = n_err;
    send(8'hF4);
    chk("f4_busy", {31'd0, busy}, 32'd1);
    chk("f4_clk_oe_after_accept", {31'd0, ps2_clk_oe}, 32'd1);
    frame(1'b0, got);
    chk("f4_bits", {21'd0, got}, 32'h5E8);
    chk("f4_done", n_done - d0, 32'd1);
    chk("f4_err", n_err - e0, 32'd0);
    chk("f4_idle_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("f4_busy_end", {31'd0, busy}, 32'd0);
    // 0xFF: parity 1, inhibit+REQ length and start-bit placement
    d0 = n_done; e0 = n_err;
    send(8'hFF);
    frame(1'b0, got);
    chk("ff_bits", {21'd0, got}, 32'h7FE);
    chk("ff_clk_hi_len", hi_len, 32'd7201);
    chk("ff_data_rise", rise_at, 32'd7201);
    chk("ff_done", n_done - d0, 32'd1);
    chk("ff_err", n_err - e0, 32'd0);
    // device holds data high at the ack edge
    d0 = n_done; e0 = n_err;
    send(8'hF4);
    frame(1'b1, got);
    chk("nack_bits", {21'd0, got}, 32'h5E8);
    chk("nack_err", n_err - e0, 32'd1);
    chk("nack_done", n_done - d0, 32'd0);
    chk("nack_err_oe", {30'd0, err_oe}, 32'd0);
    chk("nack_idle_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    // reset during the 5th data bit of 0x00 (data line held low)
    d0 = n_done; e0 = n_err;
    send(8'h00);
    wait_release();
    cyc(20);
    for (int k = 1; k <= 5; k++) begin
      m_clk = 1'b0;
      cyc(20);
      m_clk = 1'b1;
      cyc(20);
    end
    chk("mid_data_oe", {31'd0, ps2_data_oe}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    @(negedge clk60MHz);
    rst_n = 1'b1;
    cyc(3);
    chk("mid_rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("mid_rst_no_pulse", (n_done - d0) + (n_err - e0), 32'd0);
    // 0xF4 again, with a 0xAA request pulsed while busy
    d0 = n_done; e0 = n_err;
    send(8'hF4);
    cyc(100);
    chk("busy_ready", {31'd0, tx_ready}, 32'd0);
    tx_data = 8'hAA;
    tx_valid = 1'b1;
    cyc(3);
    tx_valid = 1'b0;
    frame(1'b0, got);
    chk("after_rst_bits", {21'd0, got}, 32'h5E8);
    chk("after_rst_done", n_done - d0, 32'd1);
    chk("after_rst_err", n_err - e0, 32'd0);
    cyc(50);
    chk("aa_ignored", {31'd0, busy}, 32'd0);
`ifdef PS2_HOST_TX_TIMEOUT_EN
    // silent device: watchdog fires TMO cycles after SEND entry
    d0 = n_done; e0 = n_err;
    send(8'hF4);
    wait_release();
    n = 0;
    while (n < TMO + 50 && !err) begin
      @(negedge clk60MHz);
      n++;
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    wait_ready();
    chk("tmo_err", n_err - e0, 32'd1);
    chk("tmo_done", n_done - d0, 32'd0);
`else
    n = 0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 command transmitter. It sends one byte (for example 0xFF reset or 0xF4 enable streaming) to the mouse on the shared `ps2_clk`/`ps2_data` open-drain pair. It is the transmit counterpart of the mouse receive path. It sits beside `MouseCtl` on the same pins, and `busy` tells the receive side to ignore line activity while a command frame is in flight.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 7200: clock-inhibit length, 120 µs at 60 MHz.
- `TIMEOUT_CYCLES`, default 900000: frame watchdog, 15 ms at 60 MHz.

Ports:
- `clk60MHz` in 1: system clock. Single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_data` in 8: command byte.
- `tx_valid` in 1: request to send `tx_data`.
- `tx_ready` out 1: block idle and able to accept a byte.
- `busy` out 1: a frame is in progress (every state except IDLE).
- `done` out 1: one-cycle pulse when the frame is acknowledged by the device.
- `err` out 1: one-cycle pulse when the frame fails (no ack, or timeout).
- `ps2_clk_i` in 1: raw clock pin level.
- `ps2_data_i` in 1: raw data pin level.
- `ps2_clk_oe` out 1: 1 pulls the clock line low; 0 releases it.
- `ps2_data_oe` out 1: 1 pulls the data line low; 0 releases it.

## Operation
- Inputs: `ps2_clk_i` and `ps2_data_i` each pass through a 2-flop synchronizer. One history register on the synchronized clock gives `fall` = previous 1, current 0.
- Handshake:
  - A byte is accepted on a cycle where `tx_valid && tx_ready`.
  - `tx_data` is latched, and odd parity is computed as `~^tx_data`.
  - `tx_valid` is ignored while `busy`.
- States:
  - IDLE: both `oe` 0, `tx_ready` 1. On accept, go to INHIBIT.
  - INHIBIT: `clk_oe` 1 for exactly `INHIBIT_CYCLES` cycles, then go to REQ.
  - REQ: `clk_oe` 1 and `data_oe` 1 for one cycle (start bit asserted), then go to SEND.
  - SEND:
    - `clk_oe` 0; `data_oe` holds the current bit.
    - On each `fall`, the next bit is placed on the line: data[0]…data[7], then parity, then stop (released). A bit value of 0 means `data_oe` 1.
    - A 4-bit index counts 0..9. After the 10th `fall` (stop bit placed), go to ACK.
  - ACK:
    - On the next `fall`, if synchronized data is 0, go to WAITIDLE; otherwise go to ERR.
  - WAITIDLE: wait until synchronized clock and data are both 1, then go to DONE.
  - DONE: `done` 1 for one cycle, then go to IDLE.
  - ERR: both `oe` 0, `err` 1 for one cycle, then go to IDLE.
- Watchdog (when compiled in):
  - A counter is cleared on entry to SEND and increments every cycle in SEND, ACK and WAITIDLE.
  - Reaching `TIMEOUT_CYCLES` forces ERR from any of those states.
- `ps2_clk_oe` and `ps2_data_oe` are registered outputs. They are never driven high; external tristate logic converts `oe` into an open-drain pull-low.

## Timing
- Reset values: `ps2_clk_oe` 0, `ps2_data_oe` 0, `tx_ready` 1, `busy` 0, `done` 0, `err` 0. State is IDLE and all counters are 0.
- Reset asserted mid-frame releases both lines asynchronously, in the same instant. No `done` or `err` is produced.
- Accept cycle to `clk_oe` rising: 1 cycle.
- `clk_oe` high time is exactly `INHIBIT_CYCLES` + 1 cycles; the extra cycle is REQ.
- Pin falling edge to updated `data_oe`: at most 4 cycles (2 sync + 1 edge + 1 register). This is far inside the 50 µs the device allows.
- `done` asserts no earlier than 1 cycle after the lines are seen idle.
- `tx_ready` returns to 1 in the cycle after the `done` or `err` pulse.
- Back-to-back requests: a second byte can be accepted in that same cycle.
- Simultaneous timeout and ack `fall` in the same cycle: the timeout wins, giving ERR.

## Configuration
- `PS2_HOST_TX_TIMEOUT_EN` defined: the watchdog is compiled in, as described in Operation.
- `PS2_HOST_TX_TIMEOUT_EN` undefined:
  - There is no watchdog counter.
  - A silent device leaves the block in SEND/ACK/WAITIDLE indefinitely, until reset.
  - `err` fires only on a missing ack (data 1 at the ack edge).

## Test plan
- Send 0xF4 against a device model clocking at 12 kHz:
  - Line bits are 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - The model drives ack 0 and then releases.
  - Expect one `done` pulse, no `err`, and `tx_ready` back to 1.
- Send 0xFF:
  - Parity bit 1 observed.
  - `clk_oe` high for exactly 7201 cycles.
  - `data_oe` rises in the last of those cycles.
- Model holds data 1 at the ack edge: expect one `err` pulse, both `oe` 0, no `done`.
- Model never clocks after release, with the macro defined: expect `err` exactly 900000 cycles after SEND entry and both lines released.
- Drive `rst_n` low during the 5th data bit: both `oe` go 0 immediately, `tx_ready` becomes 1 after release, and a following 0xF4 send completes normally.
- Pulse `tx_valid` with 0xAA while busy sending 0xF4: the request is ignored and only 0xF4 appears on the line.
